logic_axi4_stream_downsizer: RTL and testbench
==============================================

// Module: logic_axi4_stream_downsizer
// PURPOSE
//  Single-clock AXI4-Stream width reducer: one wide rx beat -> RATIO narrow tx beats
//   (RATIO = RX_TDATA_BYTES / TX_TDATA_BYTES), least-significant sub-beat first.
//  Counterpart to the upsizer/packing path; sits in front of narrow sinks (serial links, narrow FIFOs).
//  With USE_TKEEP, empty trailing sub-beats of a packet's last beat are dropped.
// PARAMETERS
//  RX_TDATA_BYTES  4  rx tdata bytes; must be a multiple of TX_TDATA_BYTES (elaboration $error otherwise)
//  TX_TDATA_BYTES  1  tx tdata bytes; > 0
//  TDEST_WIDTH     1  tdest bits (0 = disabled, tx.tdest driven '0)
//  TUSER_WIDTH     1  tuser bits (0 = disabled, tx.tuser driven '0)
//  TID_WIDTH       1  tid bits (0 = disabled, tx.tid driven '0)
//  USE_TLAST       1  0: tx.tlast driven '1, packet trimming disabled
//  USE_TKEEP       1  0: tx.tkeep driven '1, every sub-beat emitted
//  USE_TSTRB       1  0: tx.tstrb driven '1
// PORTS
//  aclk      input   1   clock for both interfaces
//  areset_n  input   1   asynchronous active-low reset
//  rx        modport logic_axi4_stream_if rx  RX_TDATA_BYTES-wide input stream
//  tx        modport logic_axi4_stream_if tx  TX_TDATA_BYTES-wide output stream
// BEHAVIOUR
//  Reset (areset_n low, async): tx.tvalid=0, buffer empty, index=0, rx.tready=0 while low; all tx payload '0.
//  Storage: one rx beat register (tdata/tkeep/tstrb/tlast/tdest/tuser/tid) + sub-beat index [$clog2(RATIO)].
//  States: EMPTY (tx.tvalid=0) / SEND (tx.tvalid=1). tx.tvalid is registered.
//  rx.tready = EMPTY | (SEND & tx.tready & index==last_index). Full throughput: no bubble between rx beats.
//  rx accept (rx.tvalid & rx.tready): capture beat, index<=0, go SEND; first tx beat valid next cycle (latency 1).
//  tx sub-beat k: tdata/tkeep/tstrb = slice k of stored beat; tdest/tuser/tid replicated on every sub-beat.
//  last_index: RATIO-1, except when USE_TKEEP & USE_TLAST & stored tlast: highest k whose tkeep slice != 0;
//   if all tkeep zero on a tlast beat -> last_index=0 (one empty sub-beat with tlast keeps packet boundary).
//  tx.tlast = stored tlast & (index==last_index); never asserted on other sub-beats.
//  tx handshake (tx.tvalid & tx.tready): index<last_index -> index+1; index==last_index -> accept new rx
//   beat in same cycle if rx.tvalid (stay SEND, index<=0) else go EMPTY.
//  tx.tvalid and all tx payload stable while tx.tvalid & !tx.tready (AXI rule); tx.tvalid never drops w/o handshake.
//  Index wrap: never exceeds last_index; RATIO=1 -> index constant 0, block is a 1-deep full-rate register slice.
//  Non-last beats with zero tkeep slices are emitted unchanged (no mid-packet null-byte removal).
//  Reset mid-operation: stored beat discarded, no partial tx burst resumes after release.
// STRUCTURE
//  No new shared typedefs; state_t {EMPTY, SEND} local. RATIO/IDX_WIDTH as localparams.
//  Width-0 field disable uses the existing logic_axi4_stream_if conventions (unused-port sinks under VERILATOR).
//  One sub-module: logic_axi4_stream_downsizer_last_index - combinational priority encoder,
//   params RATIO/TX_TDATA_BYTES, in: tkeep[RX_TDATA_BYTES], tlast; out: last_index[IDX_WIDTH].
// TESTING
//  RX=4,TX=1: rx tdata=32'h44332211 tkeep=4'hF tlast=1, tx.tready=1 -> tx 11,22,33,44 on 4 consecutive cycles, tlast only on 44.
//  Same, tkeep=4'b0011 tlast=1 -> only 11,22 emitted; tlast on 22; rx.tready high in cycle 22 is accepted.
//  tkeep=4'b0000 tlast=1 -> single tx beat tkeep=0 tlast=1; tkeep=4'b0101 tlast=0 -> all 4 beats, tlast=0.
//  Back-to-back rx beats, tx.tready=1 -> 100% tx.tvalid duty, rx.tready=1 exactly every 4th cycle.
//  Random tx.tready stalls (50%) on 1000 beats -> tx payload stable under stall, scoreboard byte order/tdest/tid match.
//  Assert areset_n low during sub-beat 2 -> tx.tvalid=0 immediately; after release first tx beat is from a new rx beat.

Source files
------------

// File: rtl/logic_axi4_stream_downsizer_pkg.sv
// Shared helpers for the AXI4-Stream downsizer slice.
package logic_axi4_stream_downsizer_pkg;

    // Zero-width optional fields are still carried as a 1-bit stand-in signal.
    function automatic int clamp_width(input int width);
        return (width > 0) ? width : 1;
    endfunction

endpackage

// File: rtl/logic_axi4_stream_if.sv
// Generic AXI4-Stream bundle; disabled sideband fields keep a 1-bit minimum width.
interface logic_axi4_stream_if #(
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1
) ();
    localparam int TDEST_W = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1;
    localparam int TUSER_W = (TUSER_WIDTH > 0) ? TUSER_WIDTH : 1;
    localparam int TID_W   = (TID_WIDTH > 0) ? TID_WIDTH : 1;

    logic                     tvalid;
    logic                     tready;
    logic [TDATA_BYTES*8-1:0] tdata;
    logic [TDATA_BYTES-1:0]   tkeep;
    logic [TDATA_BYTES-1:0]   tstrb;
    logic                     tlast;
    logic [TDEST_W-1:0]       tdest;
    logic [TUSER_W-1:0]       tuser;
    logic [TID_W-1:0]         tid;

    modport rx (input tvalid, tdata, tkeep, tstrb, tlast, tdest, tuser, tid, output tready);
    modport tx (output tvalid, tdata, tkeep, tstrb, tlast, tdest, tuser, tid, input tready);
endinterface

// File: rtl/logic_axi4_stream_downsizer_last_index.sv
// Finds the final sub-beat to emit: the highest non-empty tkeep slice on a trimmed
// last beat, otherwise the full RATIO-1.
module logic_axi4_stream_downsizer_last_index
    import logic_axi4_stream_downsizer_pkg::*;
#(
    parameter int  RATIO          = 4,
    parameter int  TX_TDATA_BYTES = 1,
    localparam int RX_TDATA_BYTES = RATIO * TX_TDATA_BYTES,
    localparam int IDX_WIDTH      = clamp_width($clog2(RATIO))
) (
    input  logic [RX_TDATA_BYTES-1:0] i_tkeep,
    input  logic                      i_tlast,
    output logic [IDX_WIDTH-1:0]      o_last_index
);

    // Priority encode highest non-empty slice; an all-empty last beat still yields index 0.
    always_comb begin
        o_last_index = IDX_WIDTH'(RATIO - 1);
        if (i_tlast) begin
            o_last_index = '0;
            for (int k = 0; k < RATIO; k++) begin
                o_last_index = (|i_tkeep[k*TX_TDATA_BYTES +: TX_TDATA_BYTES]) ? IDX_WIDTH'(k) : o_last_index;
            end
        end else begin
            o_last_index = IDX_WIDTH'(RATIO - 1);
        end
    end

endmodule

// File: rtl/logic_axi4_stream_downsizer.sv
// AXI4-Stream width reducer: one wide rx beat is replayed as RATIO narrow tx beats,
// least-significant slice first, with optional trimming of empty trailing slices.
module logic_axi4_stream_downsizer
    import logic_axi4_stream_downsizer_pkg::*;
#(
    parameter int RX_TDATA_BYTES = 4,
    parameter int TX_TDATA_BYTES = 1,
    parameter int TDEST_WIDTH    = 1,
    parameter int TUSER_WIDTH    = 1,
    parameter int TID_WIDTH      = 1,
    parameter bit USE_TLAST      = 1'b1,
    parameter bit USE_TKEEP      = 1'b1,
    parameter bit USE_TSTRB      = 1'b1
) (
    input logic             aclk,
    input logic             areset_n,
    logic_axi4_stream_if.rx rx,
    logic_axi4_stream_if.tx tx
);

    localparam int RATIO     = RX_TDATA_BYTES / TX_TDATA_BYTES;
    localparam int IDX_WIDTH = clamp_width($clog2(RATIO));
    localparam int TX_BITS   = TX_TDATA_BYTES * 8;
    localparam int RX_BITS   = RX_TDATA_BYTES * 8;
    localparam int TDEST_W   = clamp_width(TDEST_WIDTH);
    localparam int TUSER_W   = clamp_width(TUSER_WIDTH);
    localparam int TID_W     = clamp_width(TID_WIDTH);
    localparam bit TRIM_EN   = USE_TKEEP && USE_TLAST;

    typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_t;

    if ((TX_TDATA_BYTES <= 0) || ((RX_TDATA_BYTES % TX_TDATA_BYTES) != 0)) begin : g_bad_ratio
        $error("RX_TDATA_BYTES must be a positive multiple of TX_TDATA_BYTES");
    end

    state_t                r_state;
    logic [IDX_WIDTH-1:0]  r_index;
    logic [RX_BITS-1:0]    r_data;
    logic [RX_TDATA_BYTES-1:0] r_keep;
    logic [RX_TDATA_BYTES-1:0] r_strb;
    logic                  r_last;
    logic [TDEST_W-1:0]    r_dest;
    logic [TUSER_W-1:0]    r_user;
    logic [TID_W-1:0]      r_id;

    state_t                w_state_nxt;
    logic [IDX_WIDTH-1:0]  w_index_nxt;
    logic [IDX_WIDTH-1:0]  w_last_index;
    logic                  w_load;
    logic                  w_at_last;

    logic_axi4_stream_downsizer_last_index #(
        .RATIO          (RATIO),
        .TX_TDATA_BYTES (TX_TDATA_BYTES)
    ) u_last_index (
        .i_tkeep      (r_keep),
        .i_tlast      (TRIM_EN && r_last),
        .o_last_index (w_last_index)
    );

    assign w_at_last = (r_index == w_last_index);

    // Next-state: refill from rx whenever the buffer is empty or its last slice is leaving.
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_load      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (rx.tvalid) begin
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                    w_index_nxt = '0;
                end else begin
                    w_state_nxt = EMPTY;
                end
            end
            SEND: begin
                if (tx.tready && w_at_last) begin
                    w_index_nxt = '0;
                    w_load      = rx.tvalid;
                    w_state_nxt = rx.tvalid ? SEND : EMPTY;
                end else if (tx.tready) begin
                    w_index_nxt = r_index + IDX_WIDTH'(1);
                end else begin
                    w_index_nxt = r_index;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
                w_index_nxt = '0;
            end
        endcase
    end

    // State and sub-beat index register.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= EMPTY;
            r_index <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
        end
    end

    // Stored rx beat; cleared on reset so tx payload reads zero.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_data <= '0;
            r_keep <= '0;
            r_strb <= '0;
            r_last <= 1'b0;
            r_dest <= '0;
            r_user <= '0;
            r_id   <= '0;
        end else if (w_load) begin
            r_data <= rx.tdata;
            r_keep <= rx.tkeep;
            r_strb <= rx.tstrb;
            r_last <= rx.tlast;
            r_dest <= rx.tdest;
            r_user <= rx.tuser;
            r_id   <= rx.tid;
        end
    end

    // rx.tready is gated by reset so nothing is accepted while areset_n is low.
    assign rx.tready = areset_n && ((r_state == EMPTY) || (tx.tready && w_at_last));
    assign tx.tvalid = (r_state == SEND);
    assign tx.tdata  = r_data[int'(r_index)*TX_BITS +: TX_BITS];
    assign tx.tkeep  = USE_TKEEP ? r_keep[int'(r_index)*TX_TDATA_BYTES +: TX_TDATA_BYTES] : '1;
    assign tx.tstrb  = USE_TSTRB ? r_strb[int'(r_index)*TX_TDATA_BYTES +: TX_TDATA_BYTES] : '1;
    assign tx.tlast  = USE_TLAST ? (r_last && w_at_last) : 1'b1;
    assign tx.tdest  = (TDEST_WIDTH > 0) ? r_dest : '0;
    assign tx.tuser  = (TUSER_WIDTH > 0) ? r_user : '0;
    assign tx.tid    = (TID_WIDTH > 0) ? r_id : '0;

endmodule

// File: tb/tb_logic_axi4_stream_downsizer.sv
// Directed and randomized bench for the 4-byte to 1-byte AXI4-Stream downsizer.
module tb_logic_axi4_stream_downsizer;

    typedef struct packed {
        logic [7:0] data;
        logic       keep;
        logic       strb;
        logic       last;
        logic [1:0] dest;
        logic       user;
        logic       id;
    } sub_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic [3:0]  strb;
        logic        last;
        logic [1:0]  dest;
        logic        user;
        logic        id;
    } beat_t;

    logic clk = 1'b0;
    logic areset_n;
    always #5 clk = ~clk;

    logic_axi4_stream_if #(.TDATA_BYTES(4), .TDEST_WIDTH(2), .TUSER_WIDTH(1), .TID_WIDTH(1)) rx_if ();
    logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1), .TID_WIDTH(1)) tx_if ();

    logic_axi4_stream_downsizer #(
        .RX_TDATA_BYTES (4),
        .TX_TDATA_BYTES (1),
        .TDEST_WIDTH    (2),
        .TUSER_WIDTH    (1),
        .TID_WIDTH      (1),
        .USE_TLAST      (1'b1),
        .USE_TKEEP      (1'b1),
        .USE_TSTRB      (1'b1)
    ) dut (
        .aclk     (clk),
        .areset_n (areset_n),
        .rx       (rx_if),
        .tx       (tx_if)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    ready_pct = 100;
    int    gap_pct   = 0;
    int    tx_expected = 0;
    int    tx_popped   = 0;
    bit    drv_busy   = 1'b0;
    bit    acc_flag   = 1'b0;
    bit    prev_stall = 1'b0;
    sub_t  prev_pack;
    beat_t drv_cur;
    beat_t drv_q[$];
    sub_t  exp_q[$];
    sub_t  log_q[$];
    int    log_cyc[$];
    int    rx_acc_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic sub_t cur_tx();
        return sub_t'({tx_if.tdata, tx_if.tkeep, tx_if.tstrb, tx_if.tlast, tx_if.tdest, tx_if.tuser, tx_if.tid});
    endfunction

    // Reference: a beat becomes 4 byte lanes, cut after the highest kept lane on a last beat.
    task automatic expand(input beat_t b);
        int   n;
        sub_t s;
        n = 4;
        if (b.last) begin
            n = 1;
            for (int k = 0; k < 4; k++) if (b.keep[k]) n = k + 1;
        end
        for (int k = 0; k < n; k++) begin
            s.data = b.data[8*k +: 8];
            s.keep = b.keep[k];
            s.strb = b.strb[k];
            s.last = b.last && (k == n - 1);
            s.dest = b.dest;
            s.user = b.user;
            s.id   = b.id;
            exp_q.push_back(s);
            tx_expected++;
        end
    endtask

    task automatic sample();
        sub_t c;
        sub_t e;
        c = cur_tx();
        acc_flag = 1'b0;
        if (prev_stall) begin
            chk("stall_tvalid", 64'(tx_if.tvalid), 64'd1);
            chk("stall_payload", 64'(c), 64'(prev_pack));
        end
        if (tx_if.tvalid && tx_if.tready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL tx_extra_beat: observed %0h expected no beat", c);
            end else begin
                e = exp_q.pop_front();
                chk("tx_beat", 64'(c), 64'(e));
                tx_popped++;
            end
            log_q.push_back(c);
            log_cyc.push_back(cyc);
        end
        prev_stall = tx_if.tvalid && !tx_if.tready;
        prev_pack  = c;
        if (rx_if.tvalid && rx_if.tready) begin
            expand(drv_cur);
            rx_acc_cyc.push_back(cyc);
            acc_flag = 1'b1;
        end
        cyc++;
    endtask

    task automatic drive();
        if (!drv_busy || acc_flag) begin
            if (drv_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                drv_cur       = drv_q.pop_front();
                drv_busy      = 1'b1;
                rx_if.tvalid  = 1'b1;
                rx_if.tdata   = drv_cur.data;
                rx_if.tkeep   = drv_cur.keep;
                rx_if.tstrb   = drv_cur.strb;
                rx_if.tlast   = drv_cur.last;
                rx_if.tdest   = drv_cur.dest;
                rx_if.tuser   = drv_cur.user;
                rx_if.tid     = drv_cur.id;
            end else begin
                drv_busy     = 1'b0;
                rx_if.tvalid = 1'b0;
            end
        end
        tx_if.tready = ($urandom_range(99) < ready_pct);
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((drv_q.size() > 0 || drv_busy || exp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_pending", 64'(exp_q.size() + drv_q.size()), 64'd0);
    endtask

    task automatic clear_logs();
        log_q.delete();
        log_cyc.delete();
        rx_acc_cyc.delete();
    endtask

    function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.data = d; b.keep = k; b.strb = ~k; b.last = l;
        b.dest = 2'd2; b.user = 1'b1; b.id = 1'b0;
        return b;
    endfunction

    initial begin
        beat_t b;
        areset_n     = 1'b0;
        rx_if.tvalid = 1'b1;
        rx_if.tdata  = 32'h0;
        rx_if.tkeep  = 4'h0;
        rx_if.tstrb  = 4'h0;
        rx_if.tlast  = 1'b0;
        rx_if.tdest  = 2'd0;
        rx_if.tuser  = 1'b0;
        rx_if.tid    = 1'b0;
        tx_if.tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tvalid", 64'(tx_if.tvalid), 64'd0);
        chk("reset_rx_tready", 64'(rx_if.tready), 64'd0);
        chk("reset_payload", 64'(cur_tx()), 64'd0);
        rx_if.tvalid = 1'b0;
        areset_n     = 1'b1;
        #1;
        chk("idle_rx_tready", 64'(rx_if.tready), 64'd1);

        // Full beat, all lanes kept.
        clear_logs();
        drv_q.push_back(mk(32'h44332211, 4'hF, 1'b1));
        run_until_idle(50);
        chk("full_count", 64'(log_q.size()), 64'd4);
        if (log_q.size() == 4) begin
            chk("full_b0", 64'(log_q[0].data), 64'h11);
            chk("full_b1", 64'(log_q[1].data), 64'h22);
            chk("full_b2", 64'(log_q[2].data), 64'h33);
            chk("full_b3", 64'(log_q[3].data), 64'h44);
            chk("full_lasts", 64'({log_q[0].last, log_q[1].last, log_q[2].last, log_q[3].last}), 64'b0001);
            chk("full_consecutive", 64'(log_cyc[3] - log_cyc[0]), 64'd3);
            chk("full_latency", 64'(log_cyc[0] - rx_acc_cyc[0]), 64'd1);
        end

        // Trimmed last beat followed immediately by another beat.
        clear_logs();
        drv_q.push_back(mk(32'h44332211, 4'b0011, 1'b1));
        drv_q.push_back(mk(32'h88776655, 4'hF, 1'b0));
        run_until_idle(50);
        chk("trim_count", 64'(log_q.size()), 64'd6);
        if (log_q.size() == 6) begin
            chk("trim_b1", 64'(log_q[1].data), 64'h22);
            chk("trim_b1_last", 64'(log_q[1].last), 64'd1);
            chk("trim_next_b", 64'(log_q[2].data), 64'h55);
            chk("trim_no_bubble", 64'(log_cyc[2] - log_cyc[1]), 64'd1);
            chk("trim_accept_cycle", 64'(rx_acc_cyc[1]), 64'(log_cyc[1]));
        end

        // All-empty last beat and sparse non-last beat.
        clear_logs();
        drv_q.push_back(mk(32'hA5A5A5A5, 4'b0000, 1'b1));
        drv_q.push_back(mk(32'hDEADBEEF, 4'b0101, 1'b0));
        run_until_idle(50);
        chk("sparse_count", 64'(log_q.size()), 64'd5);
        if (log_q.size() == 5) begin
            chk("empty_keep", 64'(log_q[0].keep), 64'd0);
            chk("empty_last", 64'(log_q[0].last), 64'd1);
            chk("sparse_keeps", 64'({log_q[1].keep, log_q[2].keep, log_q[3].keep, log_q[4].keep}), 64'b1010);
            chk("sparse_lasts", 64'({log_q[1].last, log_q[2].last, log_q[3].last, log_q[4].last}), 64'b0000);
        end

        // Back-to-back full-throughput burst.
        clear_logs();
        for (int i = 0; i < 8; i++) drv_q.push_back(mk($urandom, 4'hF, 1'b0));
        run_until_idle(100);
        chk("b2b_count", 64'(log_q.size()), 64'd32);
        if (log_q.size() == 32) chk("b2b_duty", 64'(log_cyc[31] - log_cyc[0]), 64'd31);
        for (int i = 1; i < rx_acc_cyc.size(); i++)
            chk("b2b_rx_spacing", 64'(rx_acc_cyc[i] - rx_acc_cyc[i-1]), 64'd4);

        // Reset while sub-beat 2 is on the bus.
        clear_logs();
        drv_q.push_back(mk(32'h44332211, 4'hF, 1'b1));
        for (int n = 0; n < 50 && log_q.size() < 2; n++) tick();
        chk("mid_reset_progress", 64'(log_q.size()), 64'd2);
        areset_n = 1'b0;
        #1;
        chk("mid_reset_tvalid", 64'(tx_if.tvalid), 64'd0);
        chk("mid_reset_rx_tready", 64'(rx_if.tready), 64'd0);
        exp_q.delete();
        drv_q.delete();
        drv_busy     = 1'b0;
        prev_stall   = 1'b0;
        rx_if.tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        areset_n = 1'b1;
        clear_logs();
        drv_q.push_back(mk(32'hDDCCBBAA, 4'hF, 1'b1));
        run_until_idle(50);
        chk("post_reset_count", 64'(log_q.size()), 64'd4);
        if (log_q.size() > 0) chk("post_reset_first", 64'(log_q[0].data), 64'hAA);

        // Randomized traffic with 50% tx backpressure.
        ready_pct   = 50;
        gap_pct     = 20;
        tx_expected = 0;
        tx_popped   = 0;
        for (int i = 0; i < 1000; i++) begin
            b.data = $urandom;
            b.keep = 4'($urandom_range(15));
            b.strb = 4'($urandom_range(15));
            b.last = ($urandom_range(3) == 0);
            b.dest = 2'($urandom_range(3));
            b.user = 1'($urandom_range(1));
            b.id   = 1'($urandom_range(1));
            drv_q.push_back(b);
        end
        run_until_idle(40000);
        chk("rand_beat_total", 64'(tx_popped), 64'(tx_expected));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
